// File: rtl/pe_ctrl_pkg.sv
// Shared constants for the PE array controller: FSM state codes, the default array size,
// the weight-load length and the skew offsets of the psum-zero and result-push windows.
package pe_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_W = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int ARRAY_DIM_DEF = 4;
    localparam int LOAD_W_LEN    = 16;
    localparam int PSUM_OFS      = 4;
    localparam int RES_OFS       = 5;

endpackage

// File: rtl/pe_skew_window.sv
// One skewed window bit: high while 0 <= t - offset < num_vec.
module pe_skew_window #(
    parameter int VEC_W = 8
) (
    input  logic [VEC_W:0]   t,
    input  logic [VEC_W:0]   offset,
    input  logic [VEC_W-1:0] num_vec,
    output logic             win
);

    logic [VEC_W:0] delta;

    assign delta = t - offset;
    assign win   = (t >= offset) && (delta < {1'b0, num_vec});

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for an ARRAY_DIM x ARRAY_DIM systolic PE array: weight load, skewed run, done pulse.
// Build option PE_CTRL_WEIGHT_REUSE_EN adds reuse_w_in to skip LOAD_W when weights are still valid.
module pe_array_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int ARRAY_DIM = ARRAY_DIM_DEF,
    parameter int VEC_W     = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [VEC_W-1:0]     num_vec_in,
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    input  logic                 reuse_w_in,
`endif
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 load_weight_out,
    output logic [3:0]           weight_addr_out,
    output logic [ARRAY_DIM-1:0] act_pop_out,
    output logic [ARRAY_DIM-1:0] psum_zero_out,
    output logic [ARRAY_DIM-1:0] res_push_out
);

    logic [1:0]           state, state_nxt;
    logic [3:0]           wcnt, wcnt_nxt;
    logic [VEC_W:0]       t, t_nxt, run_last;
    logic [VEC_W-1:0]     nv, nv_nxt;
    logic                 reuse_ok;
    logic                 run_nxt;
    logic [ARRAY_DIM-1:0] act_win, psum_win, res_win;

    // RUN lasts nv + ARRAY_DIM + 4 cycles; one extra counter bit keeps nv = max from wrapping.
    assign run_last = {1'b0, nv} + (VEC_W+1)'(ARRAY_DIM + 3);

`ifdef PE_CTRL_WEIGHT_REUSE_EN
    logic w_valid;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            w_valid <= 1'b0;
        else if (state == ST_LOAD_W && wcnt == 4'(LOAD_W_LEN - 1))
            w_valid <= 1'b1;
    end

    assign reuse_ok = reuse_w_in && w_valid;
`else
    assign reuse_ok = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        wcnt_nxt  = wcnt;
        t_nxt     = t;
        nv_nxt    = nv;
        case (state)
            ST_IDLE: begin
                if (start_in) begin
                    nv_nxt = num_vec_in;
                    if (num_vec_in == '0) begin
                        state_nxt = ST_DONE;
                    end else if (reuse_ok) begin
                        state_nxt = ST_RUN;
                        t_nxt     = '0;
                    end else begin
                        state_nxt = ST_LOAD_W;
                        wcnt_nxt  = '0;
                    end
                end
            end
            ST_LOAD_W: begin
                wcnt_nxt = wcnt + 4'd1;
                if (wcnt == 4'(LOAD_W_LEN - 1)) begin
                    state_nxt = ST_RUN;
                    t_nxt     = '0;
                end
            end
            ST_RUN: begin
                t_nxt = t + 1'b1;
                if (t == run_last)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign run_nxt = (state_nxt == ST_RUN);

    // Windows are evaluated on next-cycle t so that the flopped outputs line up with RUN cycle t.
    for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_win
        pe_skew_window #(.VEC_W(VEC_W)) u_act (
            .t(t_nxt), .offset((VEC_W+1)'(i)), .num_vec(nv_nxt), .win(act_win[i]));
        pe_skew_window #(.VEC_W(VEC_W)) u_psum (
            .t(t_nxt), .offset((VEC_W+1)'(PSUM_OFS + i)), .num_vec(nv_nxt), .win(psum_win[i]));
        pe_skew_window #(.VEC_W(VEC_W)) u_res (
            .t(t_nxt), .offset((VEC_W+1)'(RES_OFS + i)), .num_vec(nv_nxt), .win(res_win[i]));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= ST_IDLE;
            wcnt            <= '0;
            t               <= '0;
            nv              <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            load_weight_out <= 1'b0;
            weight_addr_out <= '0;
            act_pop_out     <= '0;
            psum_zero_out   <= '0;
            res_push_out    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
            state           <= state_nxt;
            wcnt            <= wcnt_nxt;
            t               <= t_nxt;
            nv              <= nv_nxt;
            busy_out        <= (state_nxt == ST_LOAD_W) || run_nxt;
            done_out        <= (state_nxt == ST_DONE);
            load_weight_out <= (state_nxt == ST_LOAD_W);
            weight_addr_out <= (state_nxt == ST_LOAD_W) ? wcnt_nxt : 4'd0;
            act_pop_out     <= run_nxt ? act_win  : '0;
            psum_zero_out   <= run_nxt ? psum_win : '0;
            res_push_out    <= run_nxt ? res_win  : '0;
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl (ARRAY_DIM=4, VEC_W=8): every cycle of each job is compared
// against the packed output vector expected from the window equations.
module tb_pe_array_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_vec = 8'd0;
    logic       reuse_w = 1'b0;
    logic       busy, done, load_weight;
    logic [3:0] weight_addr, act_pop, psum_zero, res_push;
    logic [18:0] obs;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    pe_array_ctrl #(.ARRAY_DIM(4), .VEC_W(8)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .start_in(start),
        .num_vec_in(num_vec),
`ifdef PE_CTRL_WEIGHT_REUSE_EN
        .reuse_w_in(reuse_w),
`endif
        .busy_out(busy),
        .done_out(done),
        .load_weight_out(load_weight),
        .weight_addr_out(weight_addr),
        .act_pop_out(act_pop),
        .psum_zero_out(psum_zero),
        .res_push_out(res_push)
    );

    // {busy, done, load_weight, weight_addr, act_pop, psum_zero, res_push}
    assign obs = {busy, done, load_weight, weight_addr, act_pop, psum_zero, res_push};

    function automatic logic [3:0] win4(input int t, input int off, input int n);
        logic [3:0] w;
        for (int i = 0; i < 4; i++)
            w[i] = (t - off - i >= 0) && (t - off - i < n);
        return w;
    endfunction

    // Drives one job from IDLE and checks every cycle up to the IDLE cycle after done.
    // pulse_t >= 0 raises start_in for one edge at that RUN cycle.
    task automatic run_job(input int n, input bit reuse, input bit loads,
                           input int pulse_t, input string name);
        int nl, nr, last;
        logic [18:0] exp;
        start   = 1'b1;
        num_vec = 8'(n);
        reuse_w = reuse;
        @(posedge clk); #1;
        start   = 1'b0;
        num_vec = ~8'(n);
        reuse_w = 1'b0;
        nl   = (n > 0 && loads) ? 16 : 0;
        nr   = (n > 0) ? n + 8 : 0;
        last = nl + nr + 1;
        for (int c = 0; c <= last; c++) begin
            if (c < nl) begin
                exp = {3'b101, 4'(c), 12'h000};
            end else if (c < nl + nr) begin
                exp = {3'b100, 4'h0, win4(c - nl, 0, n), win4(c - nl, 4, n), win4(c - nl, 5, n)};
            end else if (c == nl + nr) begin
                exp = {3'b010, 16'h0000};
            end else begin
                exp = '0;
            end
            n_checks++;
            if (obs !== exp)
                $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp);
            else
                n_pass++;
            if (c != last) begin
                if (pulse_t >= 0 && c == nl + pulse_t) begin
                    start   = 1'b1;
                    num_vec = 8'd2;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (obs !== 19'h0) $display("FAIL reset_async: got %h expected 0", obs);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 19'h0) $display("FAIL reset_held: got %h expected 0", obs);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single_vec();
        run_job(1, 1'b0, 1'b1, -1, "single_vec");
    endtask

    task automatic test_zero_vec();
        run_job(0, 1'b0, 1'b1, -1, "zero_vec");
    endtask

    task automatic test_back_to_back();
        run_job(3, 1'b0, 1'b1, -1, "b2b_first");
        run_job(2, 1'b0, 1'b1, -1, "b2b_second");
    endtask

    task automatic test_ignore_start();
        run_job(9, 1'b0, 1'b1, 3, "ignore_start");
    endtask

    task automatic test_max_vec();
        run_job(255, 1'b0, 1'b1, -1, "max_vec");
    endtask

    task automatic test_reset_mid_run();
        logic [18:0] exp;
        start   = 1'b1;
        num_vec = 8'd4;
        @(posedge clk); #1;
        start   = 1'b0;
        num_vec = 8'd0;
        repeat (22) begin
            @(posedge clk); #1;
        end
        exp = {3'b100, 4'h0, 4'b1000, 4'b0111, 4'b0011};
        n_checks++;
        if (obs !== exp) $display("FAIL mid_run_t6: got %h expected %h", obs, exp);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 19'h0) $display("FAIL mid_run_reset_now: got %h expected 0", obs);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            n_checks++;
            if (obs !== 19'h0) $display("FAIL mid_run_aborted cycle %0d: got %h expected 0", c, obs);
            else n_pass++;
            @(posedge clk); #1;
        end
        run_job(4, 1'b0, 1'b1, -1, "after_abort");
    endtask

    task automatic test_weight_reuse();
`ifdef PE_CTRL_WEIGHT_REUSE_EN
        run_job(2, 1'b0, 1'b1, -1, "reuse_first");
        run_job(2, 1'b1, 1'b0, -1, "reuse_second");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(2, 1'b1, 1'b1, -1, "reuse_after_reset");
`else
        run_job(2, 1'b0, 1'b1, -1, "no_reuse_first");
        run_job(2, 1'b1, 1'b1, -1, "no_reuse_second");
`endif
    endtask

    initial begin
        test_reset();
        test_single_vec();
        test_zero_vec();
        test_back_to_back();
        test_ignore_start();
        test_max_vec();
        test_reset_mid_run();
        test_weight_reuse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
